// File: rtl/dsp_phase_ctrl.sv
// dsp_phase_ctrl: symbol-rate strobe generator and RX phase controller.
// Sweeps every RX phase, measures bit errors over one window per phase,
// locks the phase with the fewest errors and tracks it. It re-runs the
// search when a tracking window exceeds RELOCK_THR. A manual mode drives
// the switch-selected phase instead.
module dsp_phase_ctrl #(
    parameter int PHASE_W     = 2,
    parameter int NCH         = 2,
    parameter int SETTLE_SYMS = 16,
    parameter int WINDOW_SYMS = 1024,
    parameter int CNT_W       = 16,
    parameter int RELOCK_THR  = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_enable_rx,
    input  logic               i_auto,
    input  logic [PHASE_W-1:0] i_phase_manual,
    input  logic [NCH-1:0]     i_bit_err,
    output logic               o_enable_sym,
    output logic               o_enable_rx,
    output logic [PHASE_W-1:0] o_phase,
    output logic               o_ber_rst,
    output logic               o_locked,
    output logic [CNT_W-1:0]   o_err_count,
    output logic [PHASE_W-1:0] o_best_phase,
    output logic [1:0]         o_state
);

    localparam int UPS   = 1 << PHASE_W;
    localparam int SET_W = $clog2(SETTLE_SYMS + 1);
    localparam int WIN_W = $clog2(WINDOW_SYMS + 1);
    localparam int POP_W = $clog2(NCH + 1);
    localparam int SUM_W = CNT_W + 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SETTLE  = 2'd1;
    localparam logic [1:0] S_MEASURE = 2'd2;
    localparam logic [1:0] S_TRACK   = 2'd3;

    logic [1:0]         state;
    logic               auto_r;
    logic [PHASE_W-1:0] pm_r;
    logic               auto_lat;
    logic               search_active;
    logic [SET_W-1:0]   settle_cnt;
    logic [WIN_W-1:0]   win_cnt;
    logic [CNT_W-1:0]   win_err;
    logic [CNT_W-1:0]   best_count;
    logic [PHASE_W-1:0] best_ph;
    logic [POP_W-1:0]   pop;
    logic [SUM_W-1:0]   sum_wide;
    logic [CNT_W-1:0]   win_sum;
    logic               win_end;
    logic               last_phase;
    logic               better;
    logic [PHASE_W-1:0] pick;
    logic               relock;

    assign o_state = state;

    // Free-running divider; strobe phase chosen so the first strobe lands on the 2nd edge.
    generate
        if (PHASE_W == 0) begin : g_div0
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) o_enable_sym <= 1'b0;
                else      o_enable_sym <= 1'b1;
            end
        end else begin : g_div
            logic [PHASE_W-1:0] div_cnt;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    div_cnt      <= '0;
                    o_enable_sym <= 1'b0;
                end else begin
                    div_cnt      <= div_cnt + PHASE_W'(1);
                    o_enable_sym <= (div_cnt == PHASE_W'(1));
                end
            end
        end
    endgenerate

    // Single register stage on the switch inputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_enable_rx <= 1'b0;
            auto_r      <= 1'b0;
            pm_r        <= '0;
        end else begin
            o_enable_rx <= i_enable_rx;
            auto_r      <= i_auto;
            pm_r        <= i_phase_manual;
        end
    end

    // Error popcount, saturating window sum and window-end decisions.
    always_comb begin
        pop = '0;
        for (int i = 0; i < NCH; i++) pop = pop + POP_W'(i_bit_err[i]);
        sum_wide   = SUM_W'(win_err) + SUM_W'(pop);
        win_sum    = (sum_wide > SUM_W'(CNT_MAX)) ? CNT_MAX : sum_wide[CNT_W-1:0];
        win_end    = (win_cnt == WIN_W'(WINDOW_SYMS - 1));
        last_phase = (o_phase == PHASE_W'(UPS - 1));
        better     = (win_sum < best_count);
        pick       = better ? o_phase : best_ph;
        relock     = (32'(win_sum) > RELOCK_THR);
    end

    // Phase search / tracking FSM; disable or a mode change aborts to IDLE first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            auto_lat      <= 1'b0;
            search_active <= 1'b0;
            settle_cnt    <= '0;
            win_cnt       <= '0;
            win_err       <= '0;
            best_count    <= CNT_MAX;
            best_ph       <= '0;
            o_phase       <= '0;
            o_ber_rst     <= 1'b0;
            o_locked      <= 1'b0;
            o_err_count   <= '0;
            o_best_phase  <= '0;
        end else if (!o_enable_rx || (state != S_IDLE && auto_r != auto_lat)) begin
            state      <= S_IDLE;
            o_ber_rst  <= 1'b0;
            o_locked   <= 1'b0;
            settle_cnt <= '0;
            win_cnt    <= '0;
            win_err    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state         <= S_SETTLE;
                    auto_lat      <= auto_r;
                    search_active <= auto_r;
                    o_phase       <= auto_r ? '0 : pm_r;
                    settle_cnt    <= '0;
                    best_count    <= CNT_MAX;
                    best_ph       <= '0;
                end
                S_SETTLE: begin
                    if (o_enable_sym) begin
                        if (settle_cnt == SET_W'(SETTLE_SYMS - 1)) begin
                            settle_cnt <= '0;
                            win_cnt    <= '0;
                            win_err    <= '0;
                            o_ber_rst  <= 1'b1;
                            if (search_active) begin
                                state <= S_MEASURE;
                            end else begin
                                state    <= S_TRACK;
                                o_locked <= 1'b1;
                            end
                        end else begin
                            settle_cnt <= settle_cnt + SET_W'(1);
                        end
                    end
                end
                S_MEASURE: begin
                    if (o_enable_sym) begin
                        if (win_end) begin
                            o_err_count <= win_sum;
                            win_cnt     <= '0;
                            win_err     <= '0;
                            state       <= S_SETTLE;
                            o_ber_rst   <= 1'b0;
                            if (last_phase) begin
                                o_phase       <= pick;
                                o_best_phase  <= pick;
                                search_active <= 1'b0;
                                best_count    <= CNT_MAX;
                                best_ph       <= '0;
                            end else begin
                                o_phase <= o_phase + PHASE_W'(1);
                                if (better) begin
                                    best_count <= win_sum;
                                    best_ph    <= o_phase;
                                end
                            end
                        end else begin
                            win_cnt <= win_cnt + WIN_W'(1);
                            win_err <= win_sum;
                        end
                    end
                end
                S_TRACK: begin
                    if (!auto_lat && pm_r != o_phase) begin
                        o_phase   <= pm_r;
                        state     <= S_SETTLE;
                        o_locked  <= 1'b0;
                        o_ber_rst <= 1'b0;
                        win_cnt   <= '0;
                        win_err   <= '0;
                    end else if (o_enable_sym) begin
                        if (win_end) begin
                            o_err_count <= win_sum;
                            win_cnt     <= '0;
                            win_err     <= '0;
                            if (auto_lat && relock) begin
                                state         <= S_SETTLE;
                                o_phase       <= '0;
                                search_active <= 1'b1;
                                o_locked      <= 1'b0;
                                o_ber_rst     <= 1'b0;
                            end
                        end else begin
                            win_cnt <= win_cnt + WIN_W'(1);
                            win_err <= win_sum;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dsp_phase_ctrl.sv
// tb_dsp_phase_ctrl: checks dsp_phase_ctrl against a behavioural model of
// the phase search, plus literal expectations for the key scenarios.
module tb_dsp_phase_ctrl;

    localparam int SETTLE = 16;
    localparam int WIN    = 72;
    localparam int SATV   = 127;
    localparam int THR    = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       i_enable_rx = 1'b0;
    logic       i_auto = 1'b0;
    logic [1:0] i_phase_manual = 2'd0;
    logic [1:0] i_bit_err = 2'd0;
    logic       o_enable_sym, o_enable_rx, o_ber_rst, o_locked;
    logic [1:0] o_phase, o_best_phase, o_state;
    logic [6:0] o_err_count;
    logic       c_sym, c_en_rx, c_ber_rst, c_locked;
    logic [2:0] c_phase, c_best;
    logic [15:0] c_err;
    logic [1:0] c_state;

    int n_checks = 0;
    int n_errors = 0;
    bit run = 0;

    // stimulus controls for the error driver
    bit burst = 0;
    bit rand_err = 0;
    int plan[4];
    int rem[4];
    int load_id = 0;
    int seen_id = 0;

    dsp_phase_ctrl #(.PHASE_W(2), .NCH(2), .SETTLE_SYMS(SETTLE), .WINDOW_SYMS(WIN),
                     .CNT_W(7), .RELOCK_THR(THR)) dut (
        .clk(clk), .rst(rst), .i_enable_rx(i_enable_rx), .i_auto(i_auto),
        .i_phase_manual(i_phase_manual), .i_bit_err(i_bit_err),
        .o_enable_sym(o_enable_sym), .o_enable_rx(o_enable_rx), .o_phase(o_phase),
        .o_ber_rst(o_ber_rst), .o_locked(o_locked), .o_err_count(o_err_count),
        .o_best_phase(o_best_phase), .o_state(o_state)
    );

    dsp_phase_ctrl #(.PHASE_W(3)) dut_c (
        .clk(clk), .rst(rst), .i_enable_rx(1'b0), .i_auto(1'b0),
        .i_phase_manual(3'd0), .i_bit_err(2'd0),
        .o_enable_sym(c_sym), .o_enable_rx(c_en_rx), .o_phase(c_phase),
        .o_ber_rst(c_ber_rst), .o_locked(c_locked), .o_err_count(c_err),
        .o_best_phase(c_best), .o_state(c_state)
    );

    // clock
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int m_edges, m_pm, m_stage, m_phase, m_settle, m_wcnt, m_wsum, m_errc, m_bestout;
    bit m_sym, m_en, m_auto, m_search, m_alat, m_brst, m_lock;
    int m_meas[4];

    task automatic enter_settle();
        m_stage = 1; m_settle = 0; m_brst = 0;
    endtask

    task automatic model_step();
        bit sym_pre;
        int pop, v, bi;
        sym_pre = m_sym;
        pop = $countones(i_bit_err);
        if (!m_en || (m_stage != 0 && m_auto != m_alat)) begin
            m_stage = 0; m_brst = 0; m_lock = 0;
        end else if (m_stage == 0) begin
            enter_settle();
            m_alat = m_auto; m_search = m_auto;
            m_phase = m_auto ? 0 : m_pm;
            m_wcnt = 0; m_wsum = 0;
        end else if (m_stage == 1) begin
            if (sym_pre) begin
                m_settle++;
                if (m_settle == SETTLE) begin
                    m_brst = 1; m_wcnt = 0; m_wsum = 0;
                    if (m_search) m_stage = 2;
                    else begin m_stage = 3; m_lock = 1; end
                end
            end
        end else if (m_stage == 3 && !m_alat && m_pm != m_phase) begin
            m_phase = m_pm; m_lock = 0; m_wcnt = 0; m_wsum = 0;
            enter_settle();
        end else if (sym_pre) begin
            m_wsum = m_wsum + pop;
            if (m_wsum > SATV) m_wsum = SATV;
            m_wcnt++;
            if (m_wcnt == WIN) begin
                v = m_wsum; m_errc = v; m_wcnt = 0; m_wsum = 0;
                if (m_stage == 2) begin
                    m_meas[m_phase] = v;
                    if (m_phase == 3) begin
                        bi = 0;
                        for (int i = 1; i < 4; i++) if (m_meas[i] < m_meas[bi]) bi = i;
                        m_phase = bi; m_bestout = bi; m_search = 0;
                    end else begin
                        m_phase++;
                    end
                    enter_settle();
                end else if (m_alat && v > THR) begin
                    m_phase = 0; m_search = 1; m_lock = 0;
                    enter_settle();
                end
            end
        end
        m_en = i_enable_rx; m_auto = i_auto; m_pm = i_phase_manual;
        m_edges++;
        m_sym = (m_edges >= 2) && ((m_edges - 2) % 4 == 0);
    endtask

    // model advances on every clock edge out of reset
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_edges = 0; m_pm = 0; m_stage = 0; m_phase = 0; m_settle = 0;
            m_wcnt = 0; m_wsum = 0; m_errc = 0; m_bestout = 0;
            m_sym = 0; m_en = 0; m_auto = 0; m_search = 0; m_alat = 0; m_brst = 0; m_lock = 0;
            for (int i = 0; i < 4; i++) m_meas[i] = 0;
        end else begin
            model_step();
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string nm, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    // per-cycle compare against the model, away from the active edge
    always @(negedge clk) begin
        if (run) begin
            chk("enable_sym", int'(o_enable_sym), int'(m_sym));
            chk("enable_sym_p8", int'(c_sym),
                int'((m_edges >= 2) && ((m_edges - 2) % 8 == 0)));
            chk("enable_rx", int'(o_enable_rx), int'(m_en));
            chk("phase", int'(o_phase), m_phase);
            chk("ber_rst", int'(o_ber_rst), int'(m_brst));
            chk("locked", int'(o_locked), int'(m_lock));
            chk("err_count", int'(o_err_count), m_errc);
            chk("best_phase", int'(o_best_phase), m_bestout);
        end
    end

    // ---------------- error driver ----------------
    always @(negedge clk) begin
        if (load_id != seen_id) begin
            rem = plan;
            seen_id = load_id;
        end
        if (burst) begin
            i_bit_err = 2'b11;
        end else if (rand_err) begin
            i_bit_err = 2'($urandom);
        end else if (o_enable_sym && o_ber_rst && rem[o_phase] > 0) begin
            if (rem[o_phase] >= 2) begin
                i_bit_err = 2'b11; rem[o_phase] -= 2;
            end else begin
                i_bit_err = 2'b01; rem[o_phase] -= 1;
            end
        end else begin
            i_bit_err = 2'b00;
        end
    end

    task automatic load_plan(input int p0, input int p1, input int p2, input int p3);
        plan[0] = p0; plan[1] = p1; plan[2] = p2; plan[3] = p3;
        load_id++;
    endtask

    task automatic wait_lock(input bit lvl, input int max, input string nm);
        int k;
        k = 0;
        while (o_locked !== lvl && k < max) begin @(negedge clk); k++; end
        if (o_locked !== lvl) begin
            n_checks++; n_errors++;
            $display("FAIL %s: timeout, o_locked=%0b required %0b", nm, o_locked, lvl);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        load_plan(0, 0, 0, 0);
        cycles(3);
        chk("rst_sym", int'(o_enable_sym), 0);
        chk("rst_phase", int'(o_phase), 0);
        chk("rst_ber", int'(o_ber_rst), 0);
        chk("rst_locked", int'(o_locked), 0);
        chk("rst_err", int'(o_err_count), 0);
        chk("rst_best", int'(o_best_phase), 0);
        rst = 1'b1;
        run = 1'b1;

        // divider: strobe after edge 2, then every 4 (every 8 for PHASE_W=3)
        cycles(1);
        chk("sym_edge1", int'(o_enable_sym), 0);
        cycles(1);
        chk("sym_edge2", int'(o_enable_sym), 1);
        chk("sym8_edge2", int'(c_sym), 1);
        cycles(1);
        chk("sym_edge3", int'(o_enable_sym), 0);

        // manual phase 1, then switch to 3
        i_auto = 1'b0; i_phase_manual = 2'd1; i_enable_rx = 1'b1;
        wait_lock(1'b1, 1000, "manual_lock1");
        chk("manual_phase1", int'(o_phase), 1);
        chk("manual_ber1", int'(o_ber_rst), 1);
        cycles(50);
        i_phase_manual = 2'd3;
        cycles(2);
        chk("manual_chg_locked", int'(o_locked), 0);
        chk("manual_chg_ber", int'(o_ber_rst), 0);
        wait_lock(1'b1, 1000, "manual_lock3");
        chk("manual_phase3", int'(o_phase), 3);

        // auto search with per-phase errors {5,9,0,7}
        load_plan(5, 9, 0, 7);
        i_auto = 1'b1;
        wait_lock(1'b0, 10, "auto_unlock");
        wait_lock(1'b1, 4000, "auto_lock");
        chk("auto_best", int'(o_best_phase), 2);
        chk("auto_phase", int'(o_phase), 2);
        cycles(400);
        chk("track_err0", int'(o_err_count), 0);

        // errors above threshold in TRACK restart the sweep; all-ones saturates
        burst = 1;
        wait_lock(1'b0, 1000, "relock_drop");
        chk("relock_phase0", int'(o_phase), 0);
        chk("relock_over_thr", int'(o_err_count > 7'(THR)), 1);
        wait_lock(1'b1, 4000, "burst_lock");
        wait_lock(1'b0, 1000, "relock_drop2");
        chk("sat_count", int'(o_err_count), SATV);
        burst = 0;
        wait_lock(1'b1, 4000, "post_burst_lock");
        chk("post_burst_best", int'(o_best_phase), 0);

        // tie across all phases keeps phase 0
        i_enable_rx = 1'b0;
        cycles(3);
        load_plan(3, 3, 3, 3);
        i_enable_rx = 1'b1;
        wait_lock(1'b1, 4000, "tie_lock");
        chk("tie_best", int'(o_best_phase), 0);

        // drop enable during MEASURE of phase 2, then re-search from scratch
        i_enable_rx = 1'b0;
        cycles(3);
        load_plan(4, 4, 1, 9);
        i_enable_rx = 1'b1;
        begin
            int k;
            k = 0;
            while (!(o_phase == 2'd2 && o_ber_rst) && k < 3000) begin @(negedge clk); k++; end
            chk("reach_meas2", int'(o_phase == 2'd2 && o_ber_rst), 1);
        end
        cycles(40);
        i_enable_rx = 1'b0;
        cycles(2);
        chk("drop_ber", int'(o_ber_rst), 0);
        chk("drop_locked", int'(o_locked), 0);
        load_plan(6, 2, 8, 9);
        i_enable_rx = 1'b1;
        cycles(2);
        chk("restart_phase0", int'(o_phase), 0);
        wait_lock(1'b1, 4000, "restart_lock");
        chk("restart_best", int'(o_best_phase), 1);

        // randomized mode/enable/phase changes with random errors
        rand_err = 1;
        for (int r = 0; r < 20; r++) begin
            case ($urandom_range(0, 3))
                0: i_enable_rx = ($urandom_range(0, 3) != 0);
                1: i_auto = ~i_auto;
                2: i_phase_manual = 2'($urandom);
                default: i_enable_rx = 1'b1;
            endcase
            cycles($urandom_range(50, 1200));
        end
        rand_err = 0;
        cycles(20);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
